// File: rtl/mem_io_bridge.sv
// Address decoder between the core's MEM stage and data RAM / memory-mapped I/O page.
// The I/O page holds the 7-segment display (with a digit scanner), the LEDs and synchronised switches/buttons.
module mem_io_bridge #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wen,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic [13:0] dram_addr,
  output logic        dram_wen,
  output logic [31:0] dram_wdata,
  input  logic [31:0] dram_rdata,
  input  logic [23:0] sw,
  input  logic [4:0]  btn,
  output logic [23:0] led,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_code
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  // Word offsets inside the I/O page (cpu_addr[11:2]).
  localparam logic [9:0] IO_SEG = 10'h000;
  localparam logic [9:0] IO_LED = 10'h018;
  localparam logic [9:0] IO_SW  = 10'h01C;
  localparam logic [9:0] IO_BTN = 10'h01E;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0: code = 7'h40;
      4'h1: code = 7'h79;
      4'h2: code = 7'h24;
      4'h3: code = 7'h30;
      4'h4: code = 7'h19;
      4'h5: code = 7'h12;
      4'h6: code = 7'h02;
      4'h7: code = 7'h78;
      4'h8: code = 7'h00;
      4'h9: code = 7'h10;
      4'hA: code = 7'h08;
      4'hB: code = 7'h03;
      4'hC: code = 7'h46;
      4'hD: code = 7'h21;
      4'hE: code = 7'h06;
      default: code = 7'h0E;
    endcase
    return code;
  endfunction

  logic        io_sel;
  logic [9:0]  io_word;
  logic [31:0] io_rdata;
  logic        unused_addr_bits;

  logic [31:0] seg_data_reg;
  logic [23:0] led_reg;
  logic [23:0] sw_meta_reg, sw_s_reg;
  logic [4:0]  btn_meta_reg, btn_s_reg;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [2:0]  idx_reg, idx_next;
  logic [7:0]  seg_an_reg, seg_an_next;
  logic [7:0]  seg_code_reg, seg_code_next;
  logic [3:0]  seg_nib [8];

  assign io_sel           = (cpu_addr[15:12] == 4'hF);
  assign io_word          = cpu_addr[11:2];
  assign unused_addr_bits = ^cpu_addr[1:0];

  assign dram_addr  = cpu_addr[15:2];
  assign dram_wen   = cpu_wen & ~io_sel;
  assign dram_wdata = cpu_wdata;

  always_comb begin
    io_rdata = 32'h0;
    case (io_word)
      IO_SEG:  io_rdata = seg_data_reg;
      IO_LED:  io_rdata = {8'h0, led_reg};
      IO_SW:   io_rdata = {8'h0, sw_s_reg};
      IO_BTN:  io_rdata = {27'h0, btn_s_reg};
      default: io_rdata = 32'h0;
    endcase
  end

  assign cpu_rdata = io_sel ? io_rdata : dram_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_data_reg <= 32'h0;
      led_reg      <= 24'h0;
    end else if (cpu_wen && io_sel) begin
      if (io_word == IO_SEG) seg_data_reg <= cpu_wdata;
      if (io_word == IO_LED) led_reg      <= cpu_wdata[23:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta_reg  <= 24'h0;
      sw_s_reg     <= 24'h0;
      btn_meta_reg <= 5'h0;
      btn_s_reg    <= 5'h0;
    end else begin
      sw_meta_reg  <= sw;
      sw_s_reg     <= sw_meta_reg;
      btn_meta_reg <= btn;
      btn_s_reg    <= btn_meta_reg;
    end
  end

  always_comb begin
    div_next = div_reg + DIV_W'(1);
    idx_next = idx_reg;
    if (div_reg == DIV_LAST) begin
      div_next = '0;
      idx_next = idx_reg + 3'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_nib
      assign seg_nib[gi] = seg_data_reg[4*gi+3 -: 4];
    end
  endgenerate

  // Display registers sample the current digit, so they trail idx and seg_data by one cycle.
  assign seg_an_next   = ~(8'h01 << idx_reg);
  assign seg_code_next = {1'b1, hex7(seg_nib[idx_reg])};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_reg      <= '0;
      idx_reg      <= 3'd0;
      seg_an_reg   <= 8'hFE;
      seg_code_reg <= 8'hC0;
    end else begin
      div_reg      <= div_next;
      idx_reg      <= idx_next;
      seg_an_reg   <= seg_an_next;
      seg_code_reg <= seg_code_next;
    end
  end

  assign led      = led_reg;
  assign seg_an   = seg_an_reg;
  assign seg_code = seg_code_reg;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge with a short scan divider; expected values are hand-derived.
module tb_mem_io_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic        cpu_wen;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic [13:0] dram_addr;
  logic        dram_wen;
  logic [31:0] dram_wdata;
  logic [31:0] dram_rdata;
  logic [23:0] sw;
  logic [4:0]  btn;
  logic [23:0] led;
  logic [7:0]  seg_an;
  logic [7:0]  seg_code;

  int n_tests  = 0;
  int n_failed = 0;

  // Codes for seg_data 0x1234_5678, digit 0 (nibble 8) through digit 7 (nibble 1).
  logic [7:0] exp_code [8] = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
  logic [7:0] exp_an   [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  mem_io_bridge #(.SCAN_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_wen    (cpu_wen),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .dram_addr  (dram_addr),
    .dram_wen   (dram_wen),
    .dram_wdata (dram_wdata),
    .dram_rdata (dram_rdata),
    .sw         (sw),
    .btn        (btn),
    .led        (led),
    .seg_an     (seg_an),
    .seg_code   (seg_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d;
    rst        = 1'b1;
    cpu_addr   = 16'hF060;
    cpu_wen    = 1'b1;
    cpu_wdata  = 32'h00FF_FFFF;
    dram_rdata = 32'h0;
    sw         = 24'h0;
    btn        = 5'h0;

    // Store attempted while in reset is lost.
    step();
    step();
    cpu_wen = 1'b0;
    rst     = 1'b0;
    check("reset_led", {8'h0, led}, 32'h0);
    check("reset_an", {24'h0, seg_an}, 32'hFE);
    check("reset_code", {24'h0, seg_code}, 32'hC0);

    // Store routing.
    cpu_addr = 16'h0010; cpu_wen = 1'b1; cpu_wdata = 32'h0000_00AB;
    #1;
    check("ram_wen", {31'h0, dram_wen}, 32'h1);
    check("ram_addr", {18'h0, dram_addr}, 32'h4);
    check("ram_wdata", dram_wdata, 32'h0000_00AB);
    cpu_addr = 16'hF060; cpu_wdata = 32'h00FF_FFFF;
    #1;
    check("led_store_no_ram", {31'h0, dram_wen}, 32'h0);
    step();
    check("led_store", {8'h0, led}, 32'h00FF_FFFF);
    cpu_addr = 16'hF070; cpu_wdata = 32'h1234_5678;
    #1;
    check("sw_store_no_ram", {31'h0, dram_wen}, 32'h0);
    step();
    cpu_wen = 1'b0;
    check("sw_store_led", {8'h0, led}, 32'h00FF_FFFF);
    check("sw_store_read", cpu_rdata, 32'h0);

    // Load routing.
    cpu_addr = 16'h0020; dram_rdata = 32'h1234_5678;
    #1;
    check("ram_load", cpu_rdata, 32'h1234_5678);
    cpu_addr = 16'hF063;
    #1;
    check("led_load", cpu_rdata, 32'h00FF_FFFF);
    cpu_addr = 16'hF004;
    #1;
    check("unmapped_load", cpu_rdata, 32'h0);

    // Load and store to the same register in one cycle sees the old value.
    cpu_addr = 16'hF060; cpu_wen = 1'b1; cpu_wdata = 32'h000A_BCDE;
    #1;
    check("rw_same_old", cpu_rdata, 32'h00FF_FFFF);
    step();
    cpu_wen = 1'b0;
    check("rw_same_new", {8'h0, led}, 32'h000A_BCDE);

    // Switch synchroniser: two edges of latency.
    cpu_addr = 16'hF070; sw = 24'h00A5A5;
    #1;
    check("sw_sync_e0", cpu_rdata, 32'h0);
    step();
    check("sw_sync_e1", cpu_rdata, 32'h0);
    step();
    check("sw_sync_e2", cpu_rdata, 32'h0000_A5A5);

    cpu_addr = 16'hF078; btn = 5'h15;
    step();
    check("btn_sync_e1", cpu_rdata, 32'h0);
    step();
    check("btn_sync_e2", cpu_rdata, 32'h0000_0015);

    cpu_addr = 16'hF000; cpu_wen = 1'b1; cpu_wdata = 32'hDEAD_BEEF;
    step();
    cpu_wen = 1'b0;
    check("seg_load", cpu_rdata, 32'hDEAD_BEEF);
    repeat (6) step();

    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    #1;
    check("async_an", {24'h0, seg_an}, 32'hFE);
    check("async_code", {24'h0, seg_code}, 32'hC0);
    check("async_led", {8'h0, led}, 32'h0);
    check("async_seg_read", cpu_rdata, 32'h0);
    cpu_wen = 1'b1; cpu_wdata = 32'h1234_5678;
    #1 rst = 1'b0;

    // Scanner walk: after edge k, outputs show digit (k-1)/4.
    for (int k = 1; k <= 44; k++) begin
      step();
      if (k == 1) cpu_wen = 1'b0;
      if (k >= 2) begin
        d = ((k - 1) / 4) % 8;
        check($sformatf("scan_an_k%0d", k), {24'h0, seg_an}, {24'h0, exp_an[d]});
        check($sformatf("scan_code_k%0d", k), {24'h0, seg_code}, {24'h0, exp_code[d]});
      end
    end

    // Mid-scan seg_data update while idx=3.
    cpu_wen = 1'b1; cpu_wdata = 32'hFFFF_FFFF;
    step();
    cpu_wen = 1'b0;
    check("mid_old_code", {24'h0, seg_code}, 32'h92);
    check("mid_old_an", {24'h0, seg_an}, 32'hF7);
    step();
    check("mid_new_code", {24'h0, seg_code}, 32'h8E);
    check("mid_new_an", {24'h0, seg_an}, 32'hF7);

    cpu_addr = 16'hF060; cpu_wen = 1'b1; cpu_wdata = 32'h0012_3456;
    step();
    cpu_wen = 1'b0;
    repeat (6) step();
    check("pre_rst_an", {24'h0, seg_an}, 32'hDF);
    check("pre_rst_led", {8'h0, led}, 32'h0012_3456);

    // Reset during scan, then a full dwell on digit 0.
    #2 rst = 1'b1;
    #1;
    check("scan_rst_led", {8'h0, led}, 32'h0);
    check("scan_rst_an", {24'h0, seg_an}, 32'hFE);
    #1 rst = 1'b0;
    repeat (4) step();
    check("resume_dwell_an", {24'h0, seg_an}, 32'hFE);
    step();
    check("resume_next_an", {24'h0, seg_an}, 32'hFD);
    check("resume_next_code", {24'h0, seg_code}, 32'hC0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
